// File: rtl/spi_slave_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_top
// Purpose  : Mode-1 SPI slave that shows the received low nibble on four LEDs
//            and echoes the last received byte on MISO.
// Revision : 1.0
// ============================================================================
module spi_slave_top (
    input  logic clk_12MHz,
    input  logic i_SPI_MOSI,
    input  logic i_SPI_CLK,
    input  logic i_SPI_CS,
    output logic o_SPI_MISO,
    output logic led_0,
    output logic led_1,
    output logic led_2,
    output logic led_3,
    input  logic i_Rst
);

    // Stage [1] is the synchronized value, stage [2] the edge-detect history.
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [2:0] mosi_sync_q;

    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q,  rx_byte_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_q,     miso_d;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_selected;
    logic w_mosi;

    assign w_sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign w_sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign w_cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];
    assign w_cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign w_selected  = ~cs_sync_q[1];
    assign w_mosi      =  mosi_sync_q[2];

    always_ff @(posedge clk_12MHz) begin
        if (i_Rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 3'b000;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], i_SPI_CLK};
            cs_sync_q   <= {cs_sync_q[1:0],   i_SPI_CS};
            mosi_sync_q <= {mosi_sync_q[1:0], i_SPI_MOSI};
        end
    end

    always_comb begin
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        tx_shift_d  = tx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = 1'b0;
        miso_d      = miso_q;

        // A completed byte lands one cycle after its last bit and also
        // becomes the echo source for the next byte in the same window.
        if (byte_done_q) begin
            rx_byte_d  = rx_shift_q;
            tx_shift_d = rx_shift_q;
        end

        if (w_cs_rise) begin
            rx_shift_d = 8'h00;
            bit_cnt_d  = 3'd0;
        end else if (w_selected && w_sclk_fall) begin
            rx_shift_d  = {rx_shift_q[6:0], w_mosi};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end

        if (w_cs_fall) begin
            tx_shift_d = rx_byte_q;
        end else if (w_selected && w_sclk_rise) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        if (!w_selected) begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (i_Rst) begin
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            tx_shift_q  <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            tx_shift_q  <= tx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            miso_q      <= miso_d;
        end
    end

    assign o_SPI_MISO = miso_q;
    assign led_0      = rx_byte_q[0];
    assign led_1      = rx_byte_q[1];
    assign led_2      = rx_byte_q[2];
    assign led_3      = rx_byte_q[3];

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_top
// Purpose  : Self-checking bench for spi_slave_top (directed table + random).
// Revision : 1.0
// ============================================================================
module tb_spi_slave_top;

    localparam int PH = 4;

    logic clk = 1'b0;
    logic rst;
    logic mosi;
    logic sclk;
    logic cs;
    logic miso;
    logic led_0, led_1, led_2, led_3;

    always #42 clk = ~clk;

    spi_slave_top dut (
        .clk_12MHz  (clk),
        .i_SPI_MOSI (mosi),
        .i_SPI_CLK  (sclk),
        .i_SPI_CS   (cs),
        .o_SPI_MISO (miso),
        .led_0      (led_0),
        .led_1      (led_1),
        .led_2      (led_2),
        .led_3      (led_3),
        .i_Rst      (rst)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] txb      [4];
    logic [7:0] echo_got [4];
    logic [3:0] led_got  [4];
    logic [7:0] last_rx;

    typedef struct {
        logic       sel;
        int         nbytes;
        int         tail;
        logic [7:0] data;
        logic [3:0] exp_led;
        logic [7:0] exp_echo;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [3:0] leds();
        return {led_3, led_2, led_1, led_0};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CS window: nbytes full bytes then 'tail' bits of txb[nbytes].
    task automatic txn(input logic sel, input int nbytes, input int tail);
        if (sel) cs = 1'b0;
        wait_cyc(PH);
        for (int k = 0; k <= nbytes; k++) begin
            int nb;
            nb = (k < nbytes) ? 8 : tail;
            if (nb == 0) break;
            echo_got[k] = 8'h00;
            for (int b = 0; b < nb; b++) begin
                sclk = 1'b1;
                mosi = txb[k][7-b];
                wait_cyc(PH);
                echo_got[k] = {echo_got[k][6:0], miso};
                sclk = 1'b0;
                wait_cyc(PH);
            end
            led_got[k] = leds();
        end
        wait_cyc(PH);
        cs = 1'b1;
        wait_cyc(2 * PH);
    endtask

    initial begin
        logic       sel;
        int         nbytes;
        int         tail;
        logic [7:0] start;
        logic [7:0] exp_e;

        rst  = 1'b1;
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        chk("reset_leds", {4'h0, leds()}, 8'h00);
        chk("reset_miso", {7'h0, miso}, 8'h00);

        tbl[0] = '{1'b1, 1, 0, 8'hCC, 4'hC, 8'h00};
        tbl[1] = '{1'b0, 1, 0, 8'hFF, 4'hC, 8'h00};
        tbl[2] = '{1'b1, 1, 0, 8'h05, 4'h5, 8'hCC};
        tbl[3] = '{1'b1, 0, 5, 8'hF8, 4'h5, 8'h00};
        tbl[4] = '{1'b1, 1, 0, 8'h3A, 4'hA, 8'h05};

        for (int i = 0; i < 5; i++) begin
            txb[0] = tbl[i].data;
            txn(tbl[i].sel, tbl[i].nbytes, tbl[i].tail);
            chk($sformatf("tbl%0d_echo", i), echo_got[0], tbl[i].exp_echo);
            chk($sformatf("tbl%0d_led", i), {4'h0, led_got[0]}, {4'h0, tbl[i].exp_led});
        end
        chk("idle_miso", {7'h0, miso}, 8'h00);

        // Back-to-back bytes inside one CS window.
        txb[0] = 8'hA5;
        txb[1] = 8'h5A;
        txn(1'b1, 2, 0);
        chk("b2b_led0",  {4'h0, led_got[0]}, 8'h05);
        chk("b2b_led1",  {4'h0, led_got[1]}, 8'h0A);
        chk("b2b_echo0", echo_got[0], 8'h3A);
        chk("b2b_echo1", echo_got[1], 8'hA5);
        last_rx = 8'h5A;

        for (int it = 0; it < 25; it++) begin
            sel    = ($urandom_range(0, 4) != 0);
            nbytes = $urandom_range(0, 3);
            tail   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            if (nbytes == 0 && tail == 0) nbytes = 1;
            for (int j = 0; j < 4; j++) txb[j] = 8'($urandom);
            start = last_rx;
            txn(sel, nbytes, tail);
            for (int k = 0; k < nbytes; k++) begin
                exp_e = sel ? ((k == 0) ? start : txb[k-1]) : 8'h00;
                if (sel) last_rx = txb[k];
                chk("rnd_echo", echo_got[k], exp_e);
                chk("rnd_led", {4'h0, led_got[k]}, {4'h0, last_rx[3:0]});
            end
            if (tail > 0) begin
                exp_e = sel ? ((nbytes == 0) ? start : txb[nbytes-1]) : 8'h00;
                exp_e = exp_e >> (8 - tail);
                chk("rnd_tail_echo", echo_got[nbytes], exp_e);
                chk("rnd_tail_led", {4'h0, led_got[nbytes]}, {4'h0, last_rx[3:0]});
            end
        end
        chk("rnd_idle_miso", {7'h0, miso}, 8'h00);

        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        chk("rereset_leds", {4'h0, leds()}, 8'h00);
        txb[0] = 8'h69;
        txn(1'b1, 1, 0);
        chk("rereset_echo", echo_got[0], 8'h00);
        chk("rereset_led", {4'h0, led_got[0]}, 8'h09);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
